// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and request-legality helpers for the LSU
// data-memory master.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } fsm_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Halfwords need an even address, words need a word-aligned address.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    case (funct3)
      F3_LH, F3_LHU: return addr_lo[0];
      F3_LW:         return (addr_lo != 2'b00);
      default:       return 1'b0;
    endcase
  endfunction

  // Unsigned widths only make sense for loads; 011/110/111 are never legal.
  function automatic logic is_illegal(input logic       store,
                                      input logic [2:0] funct3);
    case (funct3)
      F3_LB, F3_LH, F3_LW: return 1'b0;
      F3_LBU, F3_LHU:      return store;
      default:             return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Purely combinational byte-lane logic for the LSU.
// Store side: st_funct3/st_addr_lo/st_wdata -> st_wmask (byte enables) and
//   st_lane_wdata (store data replicated across the lanes).
// Load side: ld_funct3/ld_addr_lo/ld_rdata -> ld_data (selected byte/half,
//   sign- or zero-extended, or the full word).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_wmask,
  output logic [31:0] st_lane_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Replicating the data across every lane lets the mask alone pick the
  // bytes that land in memory, so no barrel shifter is needed.
  always_comb begin
    st_wmask      = 4'b0000;
    st_lane_wdata = st_wdata;
    case (st_funct3)
      F3_LB: begin
        st_wmask      = 4'b0001 << st_addr_lo;
        st_lane_wdata = {4{st_wdata[7:0]}};
      end
      F3_LH: begin
        st_wmask      = 4'b0011 << {st_addr_lo[1], 1'b0};
        st_lane_wdata = {2{st_wdata[15:0]}};
      end
      F3_LW: begin
        st_wmask      = 4'b1111;
      end
      default: begin
        st_wmask      = 4'b0000;
      end
    endcase
  end

  // Pick the addressed byte/half out of the word, then extend it.
  always_comb begin
    ld_byte = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
    ld_half = ld_rdata[{ld_addr_lo[1], 4'b0000} +: 16];
    case (ld_funct3)
      F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU:  ld_data = {24'h000000, ld_byte};
      F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      F3_LHU:  ld_data = {16'h0000, ld_half};
      F3_LW:   ld_data = ld_rdata;
      default: ld_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_master.sv
// Data-memory initiator for the datapath: takes one load/store at a time,
// drives a word-aligned access to the memory, waits WAIT_CYCLES (1..15)
// before sampling dmem_rdata, and returns a one-cycle aligned response.
// Ports: clk/rst (async active-high); req_* request handshake from the
//   datapath; resp_valid/resp_rdata/resp_err response; dmem_* memory side.
// Optional macro LSU_STATS_EN adds stat_loads/stat_stores/stat_errs
//   response counters.
module lsu_dmem_master
  import lsu_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] dmem_addr,
  output logic        dmem_write,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
`ifdef LSU_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_errs
`endif
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

  fsm_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        store_q, store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        resp_valid_d, resp_err_d;
  logic [31:0] resp_rdata_d;
  logic [31:0] dmem_addr_d, dmem_wdata_d;
  logic        dmem_write_d;
  logic [3:0]  dmem_wmask_d;
  logic [3:0]  st_wmask;
  logic [31:0] st_lane_wdata, ld_data;

  assign req_ready = (state_q == IDLE);

  lsu_align u_align (
    .st_funct3     (req_funct3),
    .st_addr_lo    (req_addr[1:0]),
    .st_wdata      (req_wdata),
    .st_wmask      (st_wmask),
    .st_lane_wdata (st_lane_wdata),
    .ld_funct3     (funct3_q),
    .ld_addr_lo    (addr_lo_q),
    .ld_rdata      (dmem_rdata),
    .ld_data       (ld_data)
  );

  // Next-state and next-register values. Response fields and the write
  // strobe default to 0 so they only pulse for the cycle they are set;
  // the memory writes on every edge the strobe is high.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    store_d      = store_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0000_0000;
    resp_err_d   = 1'b0;
    dmem_addr_d  = dmem_addr;
    dmem_write_d = 1'b0;
    dmem_wmask_d = dmem_wmask;
    dmem_wdata_d = dmem_wdata;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d   = req_store;
          funct3_d  = req_funct3;
          addr_lo_d = req_addr[1:0];
          if (is_illegal(req_store, req_funct3) ||
              is_misaligned(req_funct3, req_addr[1:0])) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d      = ACCESS;
            cnt_d        = WAIT_INIT;
            dmem_addr_d  = {req_addr[31:2], 2'b00};
            dmem_write_d = req_store;
            dmem_wmask_d = req_store ? st_wmask : 4'b0000;
            dmem_wdata_d = st_lane_wdata;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = store_q ? 32'h0000_0000 : ld_data;
          dmem_wmask_d = 4'b0000;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      store_q    <= 1'b0;
      funct3_q   <= 3'b000;
      addr_lo_q  <= 2'b00;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0000_0000;
      resp_err   <= 1'b0;
      dmem_addr  <= 32'h0000_0000;
      dmem_write <= 1'b0;
      dmem_wmask <= 4'b0000;
      dmem_wdata <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      store_q    <= store_d;
      funct3_q   <= funct3_d;
      addr_lo_q  <= addr_lo_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      resp_err   <= resp_err_d;
      dmem_addr  <= dmem_addr_d;
      dmem_write <= dmem_write_d;
      dmem_wmask <= dmem_wmask_d;
      dmem_wdata <= dmem_wdata_d;
    end
  end

`ifdef LSU_STATS_EN
  // Count each response by kind; store_q is still valid during RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_loads  <= 32'h0000_0000;
      stat_stores <= 32'h0000_0000;
      stat_errs   <= 32'h0000_0000;
    end else if (resp_valid) begin
      if (resp_err)     stat_errs   <= stat_errs + 32'd1;
      else if (store_q) stat_stores <= stat_stores + 32'd1;
      else              stat_loads  <= stat_loads + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Scoreboard bench for lsu_dmem_master: instance a uses WAIT_CYCLES=1,
// instance b uses WAIT_CYCLES=3, each with its own behavioural memory.
module tb_lsu_dmem_master;
  import lsu_pkg::*;

  localparam int WAIT_A = 1;
  localparam int WAIT_B = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic        req_valid_a, req_store_a, req_ready_a;
  logic [2:0]  req_funct3_a;
  logic [31:0] req_addr_a, req_wdata_a;
  logic        resp_valid_a, resp_err_a, dmem_write_a;
  logic [31:0] resp_rdata_a, dmem_addr_a, dmem_wdata_a, dmem_rdata_a;
  logic [3:0]  dmem_wmask_a;

  logic        req_valid_b, req_store_b, req_ready_b;
  logic [2:0]  req_funct3_b;
  logic [31:0] req_addr_b, req_wdata_b;
  logic        resp_valid_b, resp_err_b, dmem_write_b;
  logic [31:0] resp_rdata_b, dmem_addr_b, dmem_wdata_b, dmem_rdata_b;
  logic [3:0]  dmem_wmask_b;

`ifdef LSU_STATS_EN
  logic [31:0] stat_loads_a, stat_stores_a, stat_errs_a;
  logic [31:0] stat_loads_b, stat_stores_b, stat_errs_b;
`endif

  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   wr_count_a = 0;
  int   wr_count_b = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  assign dmem_rdata_a = mem_a[dmem_addr_a[11:2]];
  assign dmem_rdata_b = mem_b[dmem_addr_b[11:2]];

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  lsu_dmem_master #(.WAIT_CYCLES(WAIT_A)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_store(req_store_a),
    .req_funct3(req_funct3_a), .req_addr(req_addr_a), .req_wdata(req_wdata_a),
    .resp_valid(resp_valid_a), .resp_rdata(resp_rdata_a), .resp_err(resp_err_a),
    .dmem_addr(dmem_addr_a), .dmem_write(dmem_write_a), .dmem_wmask(dmem_wmask_a),
    .dmem_wdata(dmem_wdata_a), .dmem_rdata(dmem_rdata_a)
`ifdef LSU_STATS_EN
    , .stat_loads(stat_loads_a), .stat_stores(stat_stores_a), .stat_errs(stat_errs_a)
`endif
  );

  lsu_dmem_master #(.WAIT_CYCLES(WAIT_B)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_store(req_store_b),
    .req_funct3(req_funct3_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b), .resp_err(resp_err_b),
    .dmem_addr(dmem_addr_b), .dmem_write(dmem_write_b), .dmem_wmask(dmem_wmask_b),
    .dmem_wdata(dmem_wdata_b), .dmem_rdata(dmem_rdata_b)
`ifdef LSU_STATS_EN
    , .stat_loads(stat_loads_b), .stat_stores(stat_stores_b), .stat_errs(stat_errs_b)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Waits (bounded) for req_ready, drives one request for one cycle and,
  // when push is set, queues the expected response for the monitor.
  task automatic applyStimulus(input bit sel, input bit store,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata,
                               input logic [31:0] exp_rdata,
                               input bit exp_err, input bit push);
    exp_t e;
    int   n;
    bit   rdy;
    n = 0;
    @(negedge clk);
    rdy = sel ? req_ready_b : req_ready_a;
    while (!rdy && n < 100) begin
      @(negedge clk);
      rdy = sel ? req_ready_b : req_ready_a;
      n++;
    end
    if (!rdy) checkOutput("req_ready_timeout", 32'd0, 32'd1);
    if (sel) begin
      req_valid_b = 1'b1; req_store_b = store; req_funct3_b = f3;
      req_addr_b = addr; req_wdata_b = wdata;
    end else begin
      req_valid_a = 1'b1; req_store_a = store; req_funct3_a = f3;
      req_addr_a = addr; req_wdata_a = wdata;
    end
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.cyc   = cyc + 1 + (exp_err ? 0 : (sel ? WAIT_B : WAIT_A));
    if (push) begin
      if (sel) q_b.push_back(e);
      else     q_a.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sel) req_valid_b = 1'b0;
    else     req_valid_a = 1'b0;
  endtask

  task automatic drain(input bit sel);
    int n;
    n = 0;
    while ((sel ? q_b.size() : q_a.size()) != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if ((sel ? q_b.size() : q_a.size()) != 0)
      checkOutput("drain_timeout", 32'(sel ? q_b.size() : q_a.size()), 32'd0);
  endtask

  initial begin
    int wr0;
    rst = 1'b1;
    req_valid_a = 0; req_store_a = 0; req_funct3_a = 0; req_addr_a = 0; req_wdata_a = 0;
    req_valid_b = 0; req_store_b = 0; req_funct3_b = 0; req_addr_b = 0; req_wdata_b = 0;
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_a[64] = 32'h8000_F0FE;
    mem_b[64] = 32'h8000_F0FE;

    fork
      // Cycle counter used for response-latency checks.
      forever begin
        @(posedge clk);
        cyc++;
      end
      // Byte-masked memory models, writing on every edge the strobe is high.
      forever begin
        logic [31:0] w;
        @(posedge clk);
        if (dmem_write_a) begin
          w = mem_a[dmem_addr_a[11:2]];
          for (int k = 0; k < 4; k++)
            if (dmem_wmask_a[k]) w[8*k +: 8] = dmem_wdata_a[8*k +: 8];
          mem_a[dmem_addr_a[11:2]] = w;
          wr_count_a++;
          $display("[TB] mem_a write addr=0x%08h data=0x%08h mask=%b",
                   dmem_addr_a, dmem_wdata_a, dmem_wmask_a);
        end
        if (dmem_write_b) begin
          w = mem_b[dmem_addr_b[11:2]];
          for (int k = 0; k < 4; k++)
            if (dmem_wmask_b[k]) w[8*k +: 8] = dmem_wdata_b[8*k +: 8];
          mem_b[dmem_addr_b[11:2]] = w;
          wr_count_b++;
          $display("[TB] mem_b write addr=0x%08h data=0x%08h mask=%b",
                   dmem_addr_b, dmem_wdata_b, dmem_wmask_b);
        end
      end
      // Response monitor for instance a.
      forever begin
        exp_t ea;
        @(negedge clk);
        if (!rst && resp_valid_a) begin
          if (q_a.size() == 0) checkOutput("a_unexpected_resp", 32'd1, 32'd0);
          else begin
            ea = q_a.pop_front();
            checkOutput("a_rdata", resp_rdata_a, ea.rdata);
            checkOutput("a_err", 32'(resp_err_a), 32'(ea.err));
            checkOutput("a_resp_cycle", 32'(cyc), 32'(ea.cyc));
          end
        end
      end
      // Response monitor for instance b.
      forever begin
        exp_t eb;
        @(negedge clk);
        if (!rst && resp_valid_b) begin
          if (q_b.size() == 0) checkOutput("b_unexpected_resp", 32'd1, 32'd0);
          else begin
            eb = q_b.pop_front();
            checkOutput("b_rdata", resp_rdata_b, eb.rdata);
            checkOutput("b_err", 32'(resp_err_b), 32'(eb.err));
            checkOutput("b_resp_cycle", 32'(cyc), 32'(eb.cyc));
          end
        end
      end
    join_none

    // Reset values.
    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready_a), 32'd1);
    checkOutput("rst_resp_valid", 32'(resp_valid_a), 32'd0);
    checkOutput("rst_dmem_wmask", 32'(dmem_wmask_a), 32'd0);
    rst = 1'b0;

    // Store byte to the top lane.
    wr0 = wr_count_a;
    applyStimulus(0, 1, F3_LB, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 1);
    @(negedge clk);
    checkOutput("sb_dmem_addr", dmem_addr_a, 32'h0000_1000);
    checkOutput("sb_wmask", 32'(dmem_wmask_a), 32'h8);
    checkOutput("sb_wdata", dmem_wdata_a, 32'hA5A5_A5A5);
    checkOutput("sb_write_first", 32'(dmem_write_a), 32'd1);
    @(negedge clk);
    checkOutput("sb_write_second", 32'(dmem_write_a), 32'd0);
    drain(0);
    checkOutput("sb_write_count", 32'(wr_count_a - wr0), 32'd1);

    // Load extraction, issued back to back.
    applyStimulus(0, 0, F3_LB,  32'h101, 32'h0, 32'hFFFF_FFF0, 0, 1);
    applyStimulus(0, 0, F3_LBU, 32'h101, 32'h0, 32'h0000_00F0, 0, 1);
    applyStimulus(0, 0, F3_LH,  32'h102, 32'h0, 32'hFFFF_8000, 0, 1);
    applyStimulus(0, 0, F3_LHU, 32'h102, 32'h0, 32'h0000_8000, 0, 1);
    applyStimulus(0, 0, F3_LW,  32'h100, 32'h0, 32'h8000_F0FE, 0, 1);
    applyStimulus(0, 0, F3_LB,  32'h100, 32'h0, 32'hFFFF_FFFE, 0, 1);
    drain(0);

    // Misaligned and illegal requests.
    wr0 = wr_count_a;
    applyStimulus(0, 0, F3_LW, 32'h102, 32'h0, 32'h0, 1, 1);
    @(negedge clk);
    checkOutput("lw_err_write", 32'(dmem_write_a), 32'd0);
    checkOutput("lw_err_wmask", 32'(dmem_wmask_a), 32'd0);
    applyStimulus(0, 1, F3_LH, 32'h001, 32'h1234, 32'h0, 1, 1);
    @(negedge clk);
    checkOutput("sh_err_write", 32'(dmem_write_a), 32'd0);
    checkOutput("sh_err_wmask", 32'(dmem_wmask_a), 32'd0);
    applyStimulus(0, 1, F3_LBU, 32'h100, 32'h0, 32'h0, 1, 1);
    applyStimulus(0, 0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 1);
    drain(0);
    checkOutput("err_write_count", 32'(wr_count_a - wr0), 32'd0);

    // Halfword store into the upper half, then read the word back.
    applyStimulus(0, 1, F3_LH, 32'h102, 32'h0000_1234, 32'h0, 0, 1);
    @(negedge clk);
    checkOutput("sh_wmask", 32'(dmem_wmask_a), 32'hC);
    checkOutput("sh_wdata", dmem_wdata_a, 32'h1234_1234);
    applyStimulus(0, 0, F3_LW, 32'h100, 32'h0, 32'h1234_F0FE, 0, 1);
    drain(0);

    // Store then load of the same word, back to back.
    wr0 = wr_count_a;
    applyStimulus(0, 1, F3_LW, 32'h200, 32'hDEAD_BEEF, 32'h0, 0, 1);
    applyStimulus(0, 0, F3_LW, 32'h200, 32'h0, 32'hDEAD_BEEF, 0, 1);
    drain(0);
    checkOutput("sw_lw_write_count", 32'(wr_count_a - wr0), 32'd1);

    // Longer wait: address held for 3 cycles, requests in between ignored.
    wr0 = wr_count_b;
    applyStimulus(1, 0, F3_LW, 32'h100, 32'h0, 32'h8000_F0FE, 0, 1);
    for (int i = 0; i < WAIT_B; i++) begin
      @(negedge clk);
      checkOutput("w3_dmem_addr", dmem_addr_b, 32'h0000_0100);
      checkOutput("w3_req_ready", 32'(req_ready_b), 32'd0);
      req_valid_b = 1'b1; req_store_b = 1'b1; req_funct3_b = F3_LW;
      req_addr_b = 32'h300; req_wdata_b = 32'h0000_FFFF;
      @(posedge clk);
      #1;
      req_valid_b = 1'b0;
    end
    drain(1);
    repeat (4) @(negedge clk);
    checkOutput("w3_ignored_writes", 32'(wr_count_b - wr0), 32'd0);
`ifdef LSU_STATS_EN
    checkOutput("stat_loads_pre_rst", stat_loads_b, 32'd1);
`endif

    // Reset in the middle of an ACCESS: request dropped, no response.
    applyStimulus(1, 0, F3_LW, 32'h100, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    checkOutput("mid_dmem_addr_before", dmem_addr_b, 32'h0000_0100);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_req_ready", 32'(req_ready_b), 32'd1);
    checkOutput("mid_rst_resp_valid", 32'(resp_valid_b), 32'd0);
    checkOutput("mid_rst_resp_rdata", resp_rdata_b, 32'd0);
    checkOutput("mid_rst_resp_err", 32'(resp_err_b), 32'd0);
    checkOutput("mid_rst_dmem_addr", dmem_addr_b, 32'd0);
    checkOutput("mid_rst_dmem_write", 32'(dmem_write_b), 32'd0);
    checkOutput("mid_rst_dmem_wmask", 32'(dmem_wmask_b), 32'd0);
    checkOutput("mid_rst_dmem_wdata", dmem_wdata_b, 32'd0);
`ifdef LSU_STATS_EN
    checkOutput("mid_rst_stat_loads", stat_loads_b, 32'd0);
    checkOutput("mid_rst_stat_stores", stat_stores_b, 32'd0);
    checkOutput("mid_rst_stat_errs", stat_errs_b, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    wr0 = wr_count_b;
    applyStimulus(1, 1, F3_LW, 32'h200, 32'h1122_3344, 32'h0, 0, 1);
    applyStimulus(1, 0, F3_LW, 32'h200, 32'h0, 32'h1122_3344, 0, 1);
    drain(1);
    checkOutput("post_rst_write_count", 32'(wr_count_b - wr0), 32'd1);
    repeat (2) @(negedge clk);
`ifdef LSU_STATS_EN
    checkOutput("post_rst_stat_stores", stat_stores_b, 32'd1);
    checkOutput("post_rst_stat_loads", stat_loads_b, 32'd1);
    checkOutput("post_rst_stat_errs", stat_errs_b, 32'd0);
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_master.md
Name: lsu_dmem_master

Overview:
- Initiator side of the datapath's data-memory port: accepts one load/store request at a time from the datapath and drives dmem_addr/dmem_write/dmem_wmask/dmem_wdata toward the memory model.
- Captures dmem_rdata after a fixed wait, then aligns and extends load data and returns a single-cycle response.
- Sits between the execute/memory stage of mp_datapath and the dual-port memory. The memory reads combinationally from a word-aligned address and writes on every posedge while dmem_write is high.

Parameters:
- WAIT_CYCLES, 1, cycles the address is held before dmem_rdata is sampled (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  datapath request strobe
- req_ready  out  1  block can accept a request this cycle
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  aligned and extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal funct3; valid with resp_valid
- dmem_addr  out  32  word-aligned address, {req_addr[31:2],2'b00}
- dmem_write  out  1  write strobe
- dmem_wmask  out  4  byte enables
- dmem_wdata  out  32  lane-shifted store data
- dmem_rdata  in  32  memory read data

Behaviour:
- Reset values: FSM = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, dmem_addr = 0, dmem_write = 0, dmem_wmask = 0, dmem_wdata = 0, wait counter = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1. On req_valid, latch store, funct3, addr[1:0] and the lane-shifted wdata.
  - Legal request: drive the dmem_* registers and go to ACCESS with counter = WAIT_CYCLES-1.
  - Error request: no memory activity; go to RESP with err = 1.
- Error conditions:
  - H/HU with addr[0] = 1.
  - W with addr[1:0] != 0.
  - funct3 in {011, 110, 111}, or a store with funct3 in {100, 101}.
- ACCESS:
  - req_ready = 0.
  - Store: dmem_write = 1 for exactly the first ACCESS cycle and 0 afterwards, because the memory writes on every posedge while it is high.
  - Counter decrements each cycle. At 0, sample dmem_rdata (loads) and go to RESP.
  - dmem_addr, dmem_wmask and dmem_wdata are held stable for the whole of ACCESS.
- RESP:
  - resp_valid = 1 for one cycle, then IDLE. req_ready = 0.
  - dmem_wmask and dmem_write are cleared on entry.
- Latency: legal request at cycle N gives resp_valid at N+1+WAIT_CYCLES. Error request gives resp_valid at N+1.
- Throughput: back-to-back requests are accepted on the cycle after RESP.
- Write mask and data:
  - B: mask 4'b0001 << addr[1:0]; wdata = {4{byte}}.
  - H: mask 4'b0011 << {addr[1],1'b0}; wdata = {2{half}}.
  - W: mask 4'b1111.
  - Loads: dmem_wmask = 0.
- Load extraction: select the byte at offset addr[1:0]*8, or the half at offset addr[1]*16.
  - B/H: sign-extend. BU/HU: zero-extend. W: pass through.
- req_valid while req_ready = 0 is ignored (not queued).
- Reset asserted mid-ACCESS: outputs return to reset values immediately and asynchronously, the outstanding request is dropped, and no resp_valid is issued.

Optional Feature:
- LSU_STATS_EN defined:
  - Adds outputs stat_loads, stat_stores and stat_errs, each 32 bits.
  - Each counter increments on the resp_valid cycle of its kind and wraps at 2^32. Errors count only in stat_errs.
  - All counters are cleared by rst.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package lsu_pkg:
  - enum fsm_state_t {IDLE, ACCESS, RESP}.
  - funct3 constants F3_LB=3'b000, F3_LH=3'b001, F3_LW=3'b010, F3_LBU=3'b100, F3_LHU=3'b101.
  - Function is_misaligned(funct3, addr_lo).
- One natural sub-module, lsu_align: purely combinational store-lane shift, wmask generation and load extract/extend. The FSM stays in lsu_dmem_master.

Test Plan:
- SB addr 0x0000_1003, wdata 0x0000_00A5 -> dmem_addr 0x0000_1000, wmask 4'b1000, wdata 0xA5A5_A5A5, dmem_write high exactly 1 cycle, resp_valid at N+2 with resp_err = 0.
- Memory word 0x8000_F0FE at 0x100:
  - LB 0x101 -> 0xFFFF_FFF0.
  - LBU 0x101 -> 0x0000_00F0.
  - LH 0x102 -> 0xFFFF_8000.
  - LHU 0x102 -> 0x0000_8000.
  - LW 0x100 -> 0x8000_F0FE.
- LW 0x102 and SH 0x001 -> resp_valid at N+1 with resp_err = 1, dmem_write never high, wmask = 0.
- WAIT_CYCLES = 3, LW -> dmem_addr stable for 3 cycles, resp_valid at N+4; req_valid pulses during that window are ignored.
- SW 0x200 = 0xDEAD_BEEF then LW 0x200 back-to-back -> load returns 0xDEAD_BEEF; the memory's write display fires exactly once.
- rst asserted in the middle of an LW in ACCESS -> outputs at reset values immediately; no resp_valid; after rst falls, the next SW completes normally; stat_* (LSU_STATS_EN) read 0 after the reset.
